// File: rtl/stage2_flatten_buffer.sv
// Ping-pong capture of one pooled CH-lane frame, re-emitted in channel/row/col flatten order; 2 cycles per element, full->valid after 2 edges.
// Input never stalls (a frame is dropped when its bank is still full); output is valid/ready. Optional drop counter: ST2_FLAT_DROP_CNT_EN.
module stage2_flatten_buffer #(
  parameter int CH  = 3,
  parameter int IBW = 19,
  parameter int PX  = 12,
  parameter int PY  = 12,
  localparam int N  = PX * PY,
  localparam int T  = CH * N,
  localparam int IW = (T > 1) ? $clog2(T) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_in_valid,
  input  logic [CH*IBW-1:0] i_in_fmap,
  output logic              o_ot_valid,
  input  logic              i_ot_ready,
  output logic [IBW-1:0]    o_ot_data,
  output logic [IW-1:0]     o_ot_index,
  output logic              o_ot_last,
  output logic              o_overflow
`ifdef ST2_FLAT_DROP_CNT_EN
  ,
  output logic [7:0]        o_drop_cnt
`endif
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [IW-1:0] I_LAST = IW'(T - 1);

  typedef enum logic {W_FILL, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_HOLD} r_state_t;

  logic [IBW-1:0] mem [2][CH][N];

  w_state_t      w_state;
  r_state_t      r_state;
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_ch;
  logic [IW-1:0] rd_idx;

  logic release_bank;
  logic frame_start;
  logic bank_free;
  logic wr_fill;
  logic wr_en;
  logic wr_done;

  // A bank handed back by the reader on this very edge may be refilled at once.
  assign release_bank = (r_state == R_HOLD) && o_ot_valid && i_ot_ready && o_ot_last;
  assign frame_start  = i_in_valid && (wr_cnt == '0);
  assign bank_free    = !full[wr_bank] || (release_bank && (rd_bank == wr_bank));
  assign wr_fill      = frame_start ? bank_free : (w_state == W_FILL);
  assign wr_en        = i_in_valid && wr_fill;
  assign wr_done      = i_in_valid && (wr_cnt == A_LAST);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < CH; c++) begin
        mem[wr_bank][c][wr_cnt] <= i_in_fmap[c*IBW +: IBW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state    <= W_FILL;
      wr_cnt     <= '0;
      wr_bank    <= 1'b0;
      o_overflow <= 1'b0;
`ifdef ST2_FLAT_DROP_CNT_EN
      o_drop_cnt <= 8'd0;
`endif
    end else if (i_in_valid) begin
      if (frame_start) begin
        w_state <= bank_free ? W_FILL : W_DROP;
        if (!bank_free) begin
          o_overflow <= 1'b1;
`ifdef ST2_FLAT_DROP_CNT_EN
          if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
`endif
        end
      end
      if (wr_done) begin
        wr_cnt <= '0;
        if (wr_fill) wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + AW'(1);
      end
    end
  end

  // Set and clear never hit the same bank; the set is ordered last regardless.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= 2'b00;
    end else begin
      if (release_bank) full[rd_bank] <= 1'b0;
      if (wr_en && wr_done) full[wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= R_IDLE;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      rd_ch      <= '0;
      rd_addr    <= '0;
      o_ot_valid <= 1'b0;
      o_ot_data  <= '0;
      o_ot_index <= '0;
      o_ot_last  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (full[rd_bank]) begin
            r_state <= R_READ;
            rd_idx  <= '0;
            rd_ch   <= '0;
            rd_addr <= '0;
          end
        end
        R_READ: begin
          o_ot_data  <= mem[rd_bank][rd_ch][rd_addr];
          o_ot_index <= rd_idx;
          o_ot_last  <= (rd_idx == I_LAST);
          o_ot_valid <= 1'b1;
          r_state    <= R_HOLD;
        end
        R_HOLD: begin
          if (i_ot_ready) begin
            o_ot_valid <= 1'b0;
            if (o_ot_last) begin
              rd_bank <= ~rd_bank;
              r_state <= R_IDLE;
            end else begin
              rd_idx <= rd_idx + IW'(1);
              if (rd_addr == A_LAST) begin
                rd_addr <= '0;
                rd_ch   <= rd_ch + CW'(1);
              end else begin
                rd_addr <= rd_addr + AW'(1);
              end
              r_state <= R_READ;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage2_flatten_buffer.sv
// Directed bench for stage2_flatten_buffer: frame f lane c pixel p carries f*10000 + c*1000 + p.
module tb_stage2_flatten_buffer;
  localparam int CH  = 3;
  localparam int IBW = 19;
  localparam int PX  = 12;
  localparam int PY  = 12;
  localparam int N   = PX * PY;
  localparam int T   = CH * N;
  localparam int IW  = 9;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_in_valid;
  logic [CH*IBW-1:0] i_in_fmap;
  logic              o_ot_valid;
  logic              i_ot_ready;
  logic [IBW-1:0]    o_ot_data;
  logic [IW-1:0]     o_ot_index;
  logic              o_ot_last;
  logic              o_overflow;
`ifdef ST2_FLAT_DROP_CNT_EN
  logic [7:0]        o_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage2_flatten_buffer #(.CH(CH), .IBW(IBW), .PX(PX), .PY(PY)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_in_valid (i_in_valid),
    .i_in_fmap  (i_in_fmap),
    .o_ot_valid (o_ot_valid),
    .i_ot_ready (i_ot_ready),
    .o_ot_data  (o_ot_data),
    .o_ot_index (o_ot_index),
    .o_ot_last  (o_ot_last),
    .o_overflow (o_overflow)
`ifdef ST2_FLAT_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int f, input int k);
    return 32'(f * 10000 + (k / N) * 1000 + (k % N));
  endfunction

  task automatic drive(input int f, input int p);
    i_in_valid = 1'b1;
    for (int c = 0; c < CH; c++) begin
      i_in_fmap[c*IBW +: IBW] = IBW'(f * 10000 + c * 1000 + p);
    end
  endtask

  task automatic send_frame(input int f);
    for (int p = 0; p < N; p++) begin
      @(negedge clk);
      drive(f, p);
    end
    @(negedge clk);
    i_in_valid = 1'b0;
  endtask

  // Returns on the negedge at which the n_el-th handshake is committed.
  task automatic recv_frame(input int f, input int mode, input int n_el);
    int k = 0;
    int idle = 0;
    int cyc = 0;
    logic [7:0] pat = 8'b1001_1010;
    while (k < n_el) begin
      @(negedge clk);
      cyc++;
      i_ot_ready = (mode == 0) ? 1'b1 : pat[cyc % 8];
      if (o_ot_valid) begin
        idle = 0;
        check("data", 32'(o_ot_data), exp_data(f, k));
        check("index", 32'(o_ot_index), 32'(k));
        check("last", 32'(o_ot_last), 32'(k == T - 1));
        if (i_ot_ready) k++;
      end else begin
        idle++;
        if (idle > 2000) begin
          check("valid_timeout", 32'(o_ot_valid), 32'd1);
          k = n_el;
        end
      end
    end
  endtask

  task automatic check_quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("no_extra_valid", 32'(o_ot_valid), 32'd0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    i_in_valid = 1'b0;
    i_in_fmap  = '0;
    i_ot_ready = 1'b0;
    #2;
    check("rst_valid", 32'(o_ot_valid), 32'd0);
    check("rst_data", 32'(o_ot_data), 32'd0);
    check("rst_index", 32'(o_ot_index), 32'd0);
    check("rst_last", 32'(o_ot_last), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
`ifdef ST2_FLAT_DROP_CNT_EN
    check("rst_drop_cnt", 32'(o_drop_cnt), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single frame: valid rises two edges after the full flag is set.
    send_frame(0);
    check("latency_early", 32'(o_ot_valid), 32'd0);
    @(negedge clk);
    check("latency_early2", 32'(o_ot_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(o_ot_valid), 32'd1);
    recv_frame(0, 0, T);
    check_quiet(5);
    check("single_overflow", 32'(o_overflow), 32'd0);

    // Backpressure with an irregular ready pattern.
    send_frame(1);
    recv_frame(1, 1, T);
    check_quiet(5);

    // Ping-pong: second frame written while the first drains.
    fork
      begin send_frame(2); send_frame(3); end
      begin recv_frame(2, 0, T); recv_frame(3, 0, T); end
    join
    check("pingpong_overflow", 32'(o_overflow), 32'd0);
    check_quiet(5);

    // Release bypass: last handshake of bank 0 coincides with next frame start to bank 0.
    i_ot_ready = 1'b0;
    send_frame(4);
    send_frame(5);
    check("bypass_hold_valid", 32'(o_ot_valid), 32'd1);
    recv_frame(4, 0, T);
    fork
      begin
        drive(6, 0);
        for (int p = 1; p < N; p++) begin
          @(negedge clk);
          drive(6, p);
        end
        @(negedge clk);
        i_in_valid = 1'b0;
      end
      begin recv_frame(5, 0, T); recv_frame(6, 0, T); end
    join
    check("bypass_overflow", 32'(o_overflow), 32'd0);
    check_quiet(5);

    // Overflow: both banks fill while stalled, third frame is dropped.
    i_ot_ready = 1'b0;
    send_frame(7);
    send_frame(8);
    check("ovf_before", 32'(o_overflow), 32'd0);
    send_frame(9);
    check("ovf_set", 32'(o_overflow), 32'd1);
`ifdef ST2_FLAT_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(o_drop_cnt), 32'd1);
`endif
    recv_frame(7, 0, T);
    recv_frame(8, 0, T);
    check_quiet(20);
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Reset mid-drain at output index 50.
    send_frame(10);
    recv_frame(10, 0, 50);
    @(negedge clk);
    check("pre_rst_gap", 32'(o_ot_valid), 32'd0);
    @(negedge clk);
    check("pre_rst_valid", 32'(o_ot_valid), 32'd1);
    check("pre_rst_index", 32'(o_ot_index), 32'd50);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_ot_valid), 32'd0);
    check("mid_rst_data", 32'(o_ot_data), 32'd0);
    check("mid_rst_index", 32'(o_ot_index), 32'd0);
    check("mid_rst_last", 32'(o_ot_last), 32'd0);
    check("mid_rst_overflow", 32'(o_overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_quiet(5);
    send_frame(11);
    recv_frame(11, 0, T);
    check_quiet(5);
    check("final_overflow", 32'(o_overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
